// File: rtl/crc_serial_gen.sv
// Bit-serial Galois-LFSR CRC generator: absorbs a framed serial stream, then shifts the CRC out LSB first.
// Optional receive-side check (Done/Err, CHK_MODE input) is built when CRC_CHECK_EN is defined.
module crc_serial_gen #(
  parameter int                CRC_WD = 8,
  parameter logic [CRC_WD-1:0] TAPS   = CRC_WD'(8'h07),
  parameter logic [CRC_WD-1:0] SEED   = CRC_WD'(8'hD8)
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA,
  input  logic ACTIVE,
`ifdef CRC_CHECK_EN
  input  logic CHK_MODE,
  output logic Done,
  output logic Err,
`endif
  output logic CRC,
  output logic Valid,
  output logic Busy
);

  localparam int            CW   = $clog2(CRC_WD + 1);
  localparam logic [CW-1:0] LAST = CW'(CRC_WD - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, SHIFT_OUT} state_t;

  state_t            state, state_nx;
  logic [CRC_WD-1:0] r, r_nx, r_abs;
  logic [CW-1:0]     cnt, cnt_nx;
  logic              crc_nx, valid_nx;
  logic              fb;

  // One absorbing step of the Galois LFSR; feedback always lands in the top bit.
  always_comb begin
    fb    = DATA ^ r[0];
    r_abs = {fb, r[CRC_WD-1:1] ^ ({(CRC_WD-1){fb}} & TAPS[CRC_WD-2:0])};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      r     <= SEED;
      cnt   <= '0;
      CRC   <= 1'b0;
      Valid <= 1'b0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      cnt   <= cnt_nx;
      CRC   <= crc_nx;
      Valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    r_nx     = r;
    cnt_nx   = cnt;
    crc_nx   = 1'b0;
    valid_nx = 1'b0;
    unique case (state)
      IDLE: begin
        r_nx = SEED;
        if (ACTIVE) begin
          r_nx     = r_abs;
          state_nx = SHIFT_IN;
        end
      end
      SHIFT_IN: begin
        if (ACTIVE) begin
          r_nx = r_abs;
        end else begin
          // The first CRC bit is presented on the same edge that ends the frame.
          state_nx = SHIFT_OUT;
          cnt_nx   = '0;
          crc_nx   = r[0];
          valid_nx = 1'b1;
          r_nx     = r >> 1;
        end
      end
      SHIFT_OUT: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
          r_nx     = SEED;
          cnt_nx   = '0;
        end else begin
          crc_nx   = r[0];
          valid_nx = 1'b1;
          r_nx     = r >> 1;
          cnt_nx   = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Busy = (state != IDLE);

`ifdef CRC_CHECK_EN
  logic chk, flag, mis;

  // DATA carries the received CRC bit during each cycle a CRC bit is presented.
  assign mis = chk & (DATA ^ CRC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      chk  <= 1'b0;
      flag <= 1'b0;
      Done <= 1'b0;
      Err  <= 1'b0;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      if (state == SHIFT_IN && !ACTIVE) begin
        chk  <= CHK_MODE;
        flag <= 1'b0;
      end else if (state == SHIFT_OUT) begin
        if (mis) flag <= 1'b1;
        if (cnt == LAST) begin
          Done <= 1'b1;
          Err  <= flag | mis;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_crc_serial_gen.sv
// Self-checking bench for crc_serial_gen: instance a uses default parameters, instance b uses SEED=0.
// Expected CRCs come from constants and a bit-level model of the LFSR update equation.
module tb_crc_serial_gen;

  localparam logic [7:0] TAPS_M = 8'h07;
  localparam logic [7:0] SEED_A = 8'hD8;
  localparam logic [7:0] SEED_B = 8'h00;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic DATA = 1'b0;
  logic ACTIVE = 1'b0;
  logic crc_a, valid_a, busy_a;
  logic crc_b, valid_b, busy_b;
`ifdef CRC_CHECK_EN
  logic CHK_MODE = 1'b0;
  logic done_a, err_a, done_b, err_b;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];

  always #5 CLK = ~CLK;

  crc_serial_gen u_a (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE),
`ifdef CRC_CHECK_EN
    .CHK_MODE(CHK_MODE), .Done(done_a), .Err(err_a),
`endif
    .CRC(crc_a), .Valid(valid_a), .Busy(busy_a)
  );

  crc_serial_gen #(.CRC_WD(8), .TAPS(TAPS_M), .SEED(SEED_B)) u_b (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ACTIVE(ACTIVE),
`ifdef CRC_CHECK_EN
    .CHK_MODE(CHK_MODE), .Done(done_b), .Err(err_b),
`endif
    .CRC(crc_b), .Valid(valid_b), .Busy(busy_b)
  );

  // Bit-by-bit model: top bit takes the feedback, lower bits shift down and pick up tapped feedback.
  function automatic logic [7:0] model(input logic [7:0] seed, input logic [31:0] bits, input int n);
    logic [7:0] r, nx;
    logic f;
    r = seed;
    for (int i = 0; i < n; i++) begin
      f = bits[i] ^ r[0];
      for (int k = 0; k < 7; k++) nx[k] = r[k+1] ^ (TAPS_M[k] & f);
      nx[7] = f;
      r = nx;
    end
    return r;
  endfunction

  // Drives a frame; when 'now' is set the first bit is applied in the current (negedge) slot.
  task automatic drive_frame(input logic [31:0] bits, input int n, input bit now);
    for (int i = 0; i < n; i++) begin
      if (!(now && i == 0)) @(negedge CLK);
      ACTIVE = 1'b1;
      DATA   = bits[i];
    end
    @(negedge CLK);
    ACTIVE = 1'b0;
    DATA   = 1'b0;
  endtask

  // Gathers one Valid burst from instance a (sel=0) or b (sel=1); drives act/dat after each sample.
  task automatic collect(input bit sel, input logic act, input logic dat,
                         output logic [31:0] crc, output int nv, output logic busy_after,
                         output bit tmo);
    logic v, c, b;
    crc = '0; nv = 0; busy_after = 1'b1; tmo = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge CLK);
      v = sel ? valid_b : valid_a;
      c = sel ? crc_b : crc_a;
      b = sel ? busy_b : busy_a;
      ACTIVE = act;
      DATA   = dat;
      if (v) begin
        if (nv < 32) crc[nv] = c;
        nv++;
      end else if (nv > 0) begin
        busy_after = b;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({valid_a, crc_a, busy_a, valid_b, crc_b, busy_b} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b required 000000", {valid_a, crc_a, busy_a, valid_b, crc_b, busy_b});
    end
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_default_1bit();
    logic [31:0] crc; int nv; logic ba; bit tmo; logic [7:0] e;
    exp_q.push_back(8'h6C);
    drive_frame(32'h0, 1, 1'b0);
    collect(1'b0, 1'b0, 1'b0, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e) begin
      tests_failed++; $display("FAIL default_1bit_crc: got %h required %h (timeout=%0d)", crc[7:0], e, tmo);
    end
    tests_run++;
    if (nv !== 8) begin tests_failed++; $display("FAIL default_1bit_valid_len: got %0d required 8", nv); end
    tests_run++;
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL default_1bit_busy_after: got %b required 0", ba); end
  endtask

  task automatic test_seed0_1bit();
    logic [31:0] crc; int nv; logic ba; bit tmo; logic [7:0] e;
    exp_q.push_back(8'h87);
    drive_frame(32'h1, 1, 1'b0);
    collect(1'b1, 1'b0, 1'b0, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e || nv !== 8) begin
      tests_failed++; $display("FAIL seed0_1bit_crc: got %h/%0d bits required %h/8", crc[7:0], nv, e);
    end
  endtask

  task automatic test_active_ignored();
    logic [31:0] crc; int nv; logic ba; bit tmo; logic [7:0] e;
    exp_q.push_back(8'h00);
    drive_frame(32'h0, 8, 1'b0);
    collect(1'b1, 1'b0, 1'b0, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e || nv !== 8) begin
      tests_failed++; $display("FAIL zero_frame_crc: got %h/%0d bits required %h/8", crc[7:0], nv, e);
    end
    // ACTIVE=1, DATA=1 throughout shift-out must not disturb the CRC, and a new frame follows only after IDLE.
    exp_q.push_back(8'h6C);
    exp_q.push_back(model(SEED_A, 32'h1, 1));
    drive_frame(32'h0, 1, 1'b0);
    collect(1'b0, 1'b1, 1'b1, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e || nv !== 8) begin
      tests_failed++; $display("FAIL active_ignored_crc: got %h/%0d bits required %h/8", crc[7:0], nv, e);
    end
    tests_run++;
    if (ba !== 1'b0) begin tests_failed++; $display("FAIL active_ignored_idle_gap: busy got %b required 0", ba); end
    @(negedge CLK);
    ACTIVE = 1'b0; DATA = 1'b0;
    collect(1'b0, 1'b0, 1'b0, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e || nv !== 8) begin
      tests_failed++; $display("FAIL restart_after_idle_crc: got %h/%0d bits required %h/8", crc[7:0], nv, e);
    end
  endtask

  task automatic test_reset_midshift();
    logic [31:0] crc; int nv; logic ba; bit tmo; logic [7:0] e;
    drive_frame(32'h0, 1, 1'b0);
    repeat (3) @(negedge CLK);
    tests_run++;
    if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL midshift_valid_before_rst: got %b required 1", valid_a); end
    #2 RST = 1'b1;
    #1;
    tests_run++;
    if ({valid_a, crc_a, busy_a} !== 3'b000) begin
      tests_failed++; $display("FAIL async_reset_abort: got %b required 000", {valid_a, crc_a, busy_a});
    end
    @(negedge CLK);
    RST = 1'b0;
    exp_q.push_back(8'h6C);
    drive_frame(32'h0, 1, 1'b0);
    collect(1'b0, 1'b0, 1'b0, crc, nv, ba, tmo);
    e = exp_q.pop_front();
    tests_run++;
    if (tmo || crc[7:0] !== e || nv !== 8) begin
      tests_failed++; $display("FAIL seed_restored_crc: got %h/%0d bits required %h/8", crc[7:0], nv, e);
    end
  endtask

`ifdef CRC_CHECK_EN
  task automatic test_check_mode();
    logic [7:0] rx;
    for (int pass = 0; pass < 2; pass++) begin
      rx = 8'h87;
      if (pass == 1) rx[3] = ~rx[3];
      CHK_MODE = 1'b1;
      @(negedge CLK); ACTIVE = 1'b1; DATA = 1'b1;
      @(negedge CLK); ACTIVE = 1'b0; DATA = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        DATA = rx[k];
      end
      @(negedge CLK);
      DATA = 1'b0; CHK_MODE = 1'b0;
      tests_run++;
      if (done_b !== 1'b1 || err_b !== (pass == 1)) begin
        tests_failed++; $display("FAIL check_mode_pass%0d: done=%b err=%b required done=1 err=%0d", pass, done_b, err_b, pass);
      end
      @(negedge CLK);
      tests_run++;
      if (done_b !== 1'b0) begin tests_failed++; $display("FAIL check_done_pulse_pass%0d: got %b required 0", pass, done_b); end
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] crc; int nv; logic ba; bit tmo; logic [7:0] e;
    logic [31:0] bits;
    for (int f = 0; f < 10; f++) begin
      bits = 32'($urandom_range(0, 255));
      exp_q.push_back(model(SEED_A, bits, 8));
      drive_frame(bits, 8, f != 0);
      collect(1'b0, 1'b0, 1'b0, crc, nv, ba, tmo);
      e = exp_q.pop_front();
      tests_run++;
      if (tmo || crc[7:0] !== e || nv !== 8 || ba !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_frame%0d: data %h got %h/%0d bits busy=%b required %h/8 busy=0", f, bits[7:0], crc[7:0], nv, ba, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_1bit();
    test_seed0_1bit();
    test_active_ignored();
    test_reset_midshift();
`ifdef CRC_CHECK_EN
    test_check_mode();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/crc_serial_gen.md
Name: crc_serial_gen

Overview:
Parametrised serial CRC engine: a generalised successor to the fixed 8-bit serial CRC block.
- Absorbs a bit-serial frame while ACTIVE is high into a Galois LFSR of configurable width, taps and seed.
- Shifts the resulting CRC out bit-serially, LSB first, framed by Valid.
- Sits between a serial framer and the line driver; the optional check mode lets the same block verify received frames.

Parameters:
CRC_WD  8  CRC/LFSR width in bits, 2..32
TAPS  8'h07  feedback tap mask, CRC_WD bits; bit i set means feedback XORs into r[i]
SEED  8'hD8  LFSR value loaded at reset and at end of every frame, CRC_WD bits

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-high
DATA  in  1  serial data bit, sampled on CLK when ACTIVE=1 (or in check mode, see Optional Feature)
ACTIVE  in  1  frame-in-progress qualifier
CRC  out  1  serial CRC bit, meaningful only while Valid=1
Valid  out  1  high for exactly CRC_WD cycles while CRC bits are presented
Busy  out  1  high in SHIFT_IN and SHIFT_OUT

Behaviour:
- One clock domain (CLK); reset is asynchronous and active-high (RST). All flops reset immediately on RST=1.
- Reset values: r=SEED, state=IDLE, CRC=0, Valid=0, Busy=0, bit counter=0.
- LFSR update (one bit per absorbing cycle):
  - fb = DATA ^ r[0]
  - r_next[CRC_WD-1] = fb
  - r_next[i] = r[i+1] ^ (TAPS[i] & fb) for i < CRC_WD-1
- IDLE:
  - ACTIVE=1 → absorb DATA this edge and go to SHIFT_IN.
  - ACTIVE=0 → hold r=SEED.
- SHIFT_IN:
  - ACTIVE=1 → absorb DATA each edge; frame length is unbounded.
  - ACTIVE=0 → go to SHIFT_OUT, load counter=0; no bit is absorbed on this edge.
- SHIFT_OUT, one bit per cycle:
  - Valid=1 and CRC=r[0] are registered outputs.
  - First CRC bit appears on the edge where ACTIVE is first seen low.
  - Each edge: r <= r>>1 with zero fill, counter increments.
  - After the CRC_WD-th bit has been presented: Valid=0, r<=SEED, go to IDLE.
- ACTIVE=1 during SHIFT_OUT is ignored: no absorption, no restart. Re-sampled only after returning to IDLE, so the minimum inter-frame gap is 1 IDLE cycle.
- ACTIVE high for a single cycle is a valid 1-bit frame.
- Counter width is $clog2(CRC_WD+1).
- RST asserted mid-frame or mid-shift-out aborts immediately: Valid drops the same instant, no partial CRC.

Optional Feature:
Macro: CRC_CHECK_EN
- Defined:
  - Adds input CHK_MODE (1) and outputs Done (1) and Err (1).
  - If CHK_MODE=1 when SHIFT_OUT is entered, DATA is sampled each SHIFT_OUT cycle as the received CRC bit and compared to CRC.
  - Any mismatch sets a sticky error flag.
  - On the cycle after the last CRC bit: Done=1 for one cycle, and Err=flag.
  - Flag clears on entry to SHIFT_OUT.
  - With CHK_MODE=0: Done pulses with Err=0.
  - Reset values: Done=0, Err=0.
- Undefined: ports CHK_MODE, Done and Err do not exist; DATA is ignored in SHIFT_OUT.

Test Plan:
1. Defaults; ACTIVE=1 for 1 cycle with DATA=0 → r=8'h6C; Valid high 8 cycles; CRC sequence 0,0,1,1,0,1,1,0; Busy low after.
2. SEED=0; 1-bit frame DATA=1 → r=8'h87; CRC sequence 1,1,1,0,0,0,0,1.
3. SEED=0; 8-bit frame of all zeros → CRC 8'h00, Valid exactly 8 cycles; then ACTIVE held high during shift-out → ignored, next frame starts only after IDLE.
4. RST pulsed at the 3rd CRC bit → Valid=0, CRC=0, Busy=0 asynchronously; next 1-bit DATA=0 frame reproduces 8'h6C (seed restored).
5. CRC_CHECK_EN, SEED=0, CHK_MODE=1, 1-bit frame DATA=1, DATA driven 1,1,1,0,0,0,0,1 in SHIFT_OUT → Done=1, Err=0; flip the 4th bit → Done=1, Err=1.
6. Back-to-back 10 random 8-bit frames with 1-cycle gaps → each CRC matches the software model of the update equation above.
